// File: rtl/action_reset_request_gen_pkg.sv
// action_reset_request_gen_pkg: shared FSM encoding and reset-cause bit layout.
package action_reset_request_gen_pkg;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      HOLDOFF = 2'd2
   } stateT;
   localparam int CauseWidth = 3;
   localparam int CauseHost = 0;
   localparam int CauseErr = 1;
   localparam int CauseWd = 2;
   function automatic logic [CauseWidth-1:0] packCause(logic wd, logic err, logic host);
      logic [CauseWidth-1:0] c;
      c = '0;
      c[CauseWd] = wd;
      c[CauseErr] = err;
      c[CauseHost] = host;
      return c;
   endfunction
endpackage

// File: rtl/action_reset_request_gen_if.sv
// action_reset_request_gen_if: reset sources in, request and status out.
interface action_reset_request_gen_if #(parameter int CountSize = 8);
   import action_reset_request_gen_pkg::*;
   logic hostRstCmd;
   logic errorFlag;
   logic kernelBusy;
   logic kernelActivity;
   logic wdEnable;
   logic sysRstReq;
   logic [CauseWidth-1:0] rstCause;
   logic [CountSize-1:0] rstCount;
   logic wdExpired;
   modport master (
      output hostRstCmd, errorFlag, kernelBusy, kernelActivity, wdEnable,
      input  sysRstReq, rstCause, rstCount, wdExpired
   );
   modport slave (
      input  hostRstCmd, errorFlag, kernelBusy, kernelActivity, wdEnable,
      output sysRstReq, rstCause, rstCount, wdExpired
   );
endinterface

// File: rtl/action_reset_request_gen_watchdog.sv
// action_reset_watchdog: counts busy cycles without progress while idle and flags a hang.
module action_reset_watchdog
   import action_reset_request_gen_pkg::*;
#(
   parameter int WdLimit = 1000000,
   parameter int WdCounterSize = 20
) (
   input  logic  clk,
   input  logic  sysRstN,
   input  logic  wdEnable,
   input  logic  kernelBusy,
   input  logic  kernelActivity,
   input  stateT state,
   output logic  wdTimeout,
   output logic  wdExpired
);
   logic [WdCounterSize-1:0] wdCnt;
   logic inc;
   assign inc = wdEnable & kernelBusy & ~kernelActivity & (state == IDLE);
   assign wdTimeout = inc & (wdCnt == WdCounterSize'(WdLimit - 1));
   always_ff @(posedge clk) begin
      if (!sysRstN) begin
         wdCnt <= '0;
         wdExpired <= 1'b0;
      end else begin
         wdCnt <= (inc & ~wdTimeout) ? wdCnt + 1'b1 : '0;
         wdExpired <= wdTimeout;
      end
   end
endmodule

// File: rtl/action_reset_request_gen.sv
// action_reset_request_gen: merges host, error-edge and watchdog sources into fixed-width reset pulses.
module action_reset_request_gen
   import action_reset_request_gen_pkg::*;
#(
   parameter int ReqCycles = 4,
   parameter int HoldoffCycles = 32,
   parameter int CycleCounterSize = 6,
   parameter int WdLimit = 1000000,
   parameter int WdCounterSize = 20,
   parameter int CountSize = 8
) (
   input logic clk,
   input logic sysRstN,
   action_reset_request_gen_if.slave bus
);
   localparam logic [CycleCounterSize-1:0] ReqLoad = CycleCounterSize'(ReqCycles - 1);
   localparam logic [CycleCounterSize-1:0] HoldLoad = CycleCounterSize'(HoldoffCycles - 1);
   stateT state, stateNext;
   logic [CycleCounterSize-1:0] cnt, cntNext;
   logic pending, pendNext;
   logic [CauseWidth-1:0] pendCause, pendCauseNext, rstCause, causeNext, trigCause;
   logic [CountSize-1:0] rstCount;
   logic sysRstReq, errPrev, errRise, wdTimeout, wdExpired, trig, issue;
   assign errRise = bus.errorFlag & ~errPrev;
   assign trigCause = packCause(wdTimeout, errRise, bus.hostRstCmd);
   assign trig = |trigCause;
   assign bus.sysRstReq = sysRstReq;
   assign bus.rstCause = rstCause;
   assign bus.rstCount = rstCount;
   assign bus.wdExpired = wdExpired;
   action_reset_watchdog #(
      .WdLimit(WdLimit),
      .WdCounterSize(WdCounterSize)
   ) watchdog (
      .clk(clk),
      .sysRstN(sysRstN),
      .wdEnable(bus.wdEnable),
      .kernelBusy(bus.kernelBusy),
      .kernelActivity(bus.kernelActivity),
      .state(state),
      .wdTimeout(wdTimeout),
      .wdExpired(wdExpired)
   );
   always_comb begin
      stateNext = state;
      cntNext = cnt;
      pendNext = pending;
      pendCauseNext = pendCause;
      causeNext = rstCause;
      issue = 1'b0;
      case (state)
         IDLE: if (trig) begin
            stateNext = ASSERT;
            cntNext = ReqLoad;
            causeNext = trigCause;
            issue = 1'b1;
         end
         ASSERT: begin
            stateNext = (cnt == '0) ? HOLDOFF : ASSERT;
            cntNext = (cnt == '0) ? HoldLoad : cnt - 1'b1;
            pendNext = pending | trig;
            pendCauseNext = pendCause | trigCause;
         end
         HOLDOFF: if (cnt != '0) begin
            cntNext = cnt - 1'b1;
            pendNext = pending | trig;
            pendCauseNext = pendCause | trigCause;
         end else if (pending | trig) begin
            // a trigger on the final holdoff cycle joins the pending request
            stateNext = ASSERT;
            cntNext = ReqLoad;
            causeNext = pendCause | trigCause;
            issue = 1'b1;
            pendNext = 1'b0;
            pendCauseNext = '0;
         end else begin
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!sysRstN) begin
         state <= IDLE;
         cnt <= '0;
         pending <= 1'b0;
         pendCause <= '0;
         rstCause <= '0;
         rstCount <= '0;
         sysRstReq <= 1'b0;
         errPrev <= 1'b0;
      end else begin
         state <= stateNext;
         cnt <= cntNext;
         pending <= pendNext;
         pendCause <= pendCauseNext;
         rstCause <= causeNext;
         rstCount <= (issue & ~&rstCount) ? rstCount + 1'b1 : rstCount;
         sysRstReq <= (stateNext == ASSERT);
         errPrev <= bus.errorFlag;
      end
   end
endmodule

// File: tb/tb_action_reset_request_gen.sv
// tb_action_reset_request_gen: timeline reference model feeding a scoreboard checked every cycle.
module tb_action_reset_request_gen;
   localparam int R = 3;
   localparam int H = 6;
   localparam int WL = 16;
   localparam int CS = 3;
   typedef struct {
      logic req;
      logic [2:0] cause;
      logic [CS-1:0] count;
      logic wdx;
   } expT;
   logic clk = 1'b0;
   logic sysRstN;
   expT expQ[$];
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;
   action_reset_request_gen_if #(.CountSize(CS)) bus ();
   action_reset_request_gen #(
      .ReqCycles(R),
      .HoldoffCycles(H),
      .CycleCounterSize(3),
      .WdLimit(WL),
      .WdCounterSize(5),
      .CountSize(CS)
   ) dut (
      .clk(clk),
      .sysRstN(sysRstN),
      .bus(bus)
   );
   // model: a request window starts at edge s; pulse covers edges s..s+R-1, holdoff ends at s+R+H
   int t = 0;
   int s = 0;
   int wdRun = 0;
   int count = 0;
   bit active = 0;
   bit pend = 0;
   bit errPrev = 0;
   logic [2:0] pendCause = '0;
   logic [2:0] cause = '0;
   task automatic startReq(input logic [2:0] c);
      s = t;
      active = 1;
      cause = c;
      count = (count < (2 ** CS - 1)) ? count + 1 : count;
      pend = 0;
      pendCause = '0;
   endtask
   always @(posedge clk) begin : model
      bit errRise, to, idle;
      logic [2:0] tc;
      expT e;
      t++;
      to = 0;
      if (!sysRstN) begin
         active = 0;
         pend = 0;
         pendCause = '0;
         cause = '0;
         count = 0;
         wdRun = 0;
         errPrev = 0;
      end else begin
         errRise = bus.errorFlag && !errPrev;
         errPrev = bus.errorFlag;
         idle = !active || t > s + R + H;
         if (bus.wdEnable && bus.kernelBusy && !bus.kernelActivity && idle) begin
            wdRun++;
            if (wdRun == WL) begin
               to = 1;
               wdRun = 0;
            end
         end else wdRun = 0;
         tc = {to, errRise, bus.hostRstCmd};
         if (idle) begin
            if (tc != 0) startReq(tc);
         end else if (t == s + R + H) begin
            if (pend || tc != 0) startReq(pendCause | tc);
         end else if (tc != 0) begin
            pend = 1;
            pendCause = pendCause | tc;
         end
      end
      e.req = active && t >= s && t < s + R;
      e.cause = cause;
      e.count = CS'(count);
      e.wdx = to;
      expQ.push_back(e);
   end
   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask
   always @(posedge clk) begin : monitor
      expT e;
      #1;
      if (expQ.size() == 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard at %0t: got no expectation expected one", $time);
      end else begin
         e = expQ.pop_front();
         chk("sysRstReq", int'(bus.sysRstReq), int'(e.req));
         chk("rstCause", int'(bus.rstCause), int'(e.cause));
         chk("rstCount", int'(bus.rstCount), int'(e.count));
         chk("wdExpired", int'(bus.wdExpired), int'(e.wdx));
      end
   end
   task automatic waitCyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic hostPulse();
      bus.hostRstCmd = 1'b1;
      waitCyc(1);
      bus.hostRstCmd = 1'b0;
   endtask
   initial begin
      sysRstN = 1'b0;
      bus.hostRstCmd = 1'b0;
      bus.errorFlag = 1'b1;
      bus.kernelBusy = 1'b0;
      bus.kernelActivity = 1'b0;
      bus.wdEnable = 1'b0;
      waitCyc(3);
      sysRstN = 1'b1;
      waitCyc(15);
      bus.errorFlag = 1'b0;
      waitCyc(5);
      hostPulse();
      waitCyc(4);
      hostPulse();
      waitCyc(20);
      bus.errorFlag = 1'b1;
      hostPulse();
      waitCyc(20);
      bus.errorFlag = 1'b0;
      waitCyc(2);
      bus.wdEnable = 1'b1;
      bus.kernelBusy = 1'b1;
      waitCyc(60);
      for (int i = 0; i < 60; i++) begin
         bus.kernelActivity = (i % 10 == 0);
         waitCyc(1);
      end
      bus.kernelActivity = 1'b0;
      bus.wdEnable = 1'b0;
      bus.kernelBusy = 1'b0;
      waitCyc(15);
      hostPulse();
      hostPulse();
      sysRstN = 1'b0;
      waitCyc(1);
      sysRstN = 1'b1;
      waitCyc(20);
      for (int i = 0; i < 10; i++) begin
         hostPulse();
         waitCyc(12);
      end
      bus.wdEnable = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         sysRstN = ($urandom_range(0, 299) != 0);
         bus.hostRstCmd = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 24) == 0) bus.errorFlag = ~bus.errorFlag;
         if ($urandom_range(0, 29) == 0) bus.kernelBusy = ~bus.kernelBusy;
         if ($urandom_range(0, 99) == 0) bus.wdEnable = ~bus.wdEnable;
         bus.kernelActivity = ($urandom_range(0, 39) == 0);
         waitCyc(1);
      end
      sysRstN = 1'b1;
      bus.hostRstCmd = 1'b0;
      waitCyc(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/action_reset_request_gen.md
Name: action_reset_request_gen

Overview:
- Upstream of the action reset handler; produces its system reset request input (sysRstReq).
- Merges three reset sources into one clean request pulse of fixed width, followed by a holdoff window:
  - a host soft-reset command,
  - rising edges of a kernel error flag,
  - a kernel-hang watchdog.
- Records the cause of the last request and a saturating count of requests for host status reads.

Parameters:
- ReqCycles, 4: cycles sysRstReq is held high per request; must be >=1.
- HoldoffCycles, 32: cycles after the pulse during which no new pulse starts; must be >=1.
- CycleCounterSize, 6: width of the shared pulse/holdoff counter; must hold max(ReqCycles,HoldoffCycles)-1.
- WdLimit, 1000000: idle-while-busy cycles before a watchdog timeout; must be >=1.
- WdCounterSize, 20: watchdog counter width; must hold WdLimit.
- CountSize, 8: width of rstCount.

Ports:
- clk  in  1  system clock; single clock domain.
- sysRstN  in  1  reset, synchronous, active-low.
- hostRstCmd  in  1  single-cycle soft-reset command from the control register write.
- errorFlag  in  1  kernel error level; only its rising edge triggers.
- kernelBusy  in  1  kernel is executing.
- kernelActivity  in  1  kernel progress strobe; clears the watchdog.
- wdEnable  in  1  watchdog enable.
- sysRstReq  out  1  registered reset request to the reset handler.
- rstCause  out  3  {watchdog, error, host} sources of the most recent request.
- rstCount  out  CountSize  saturating number of requests issued.
- wdExpired  out  1  one-cycle pulse on watchdog timeout.

Behaviour:
- Reset: any posedge clk with sysRstN=0 sets the following:
  - state IDLE; sysRstReq=0; rstCause=0; rstCount=0; wdExpired=0;
  - watchdog counter=0; pending=0; pendCause=0; errPrev=0.
- Error edge: errRise = errorFlag & ~errPrev; errPrev is registered every cycle.
  - If errorFlag is already high when reset releases, exactly one trigger follows.
- Watchdog counter:
  - Increments when wdEnable & kernelBusy & ~kernelActivity & state==IDLE.
  - Clears otherwise.
  - When the counter equals WdLimit-1 and would increment: wdTimeout=1 combinationally that cycle, the counter clears, and wdExpired=1 on the next cycle.
- trig = hostRstCmd | errRise | wdTimeout; trigCause = {wdTimeout, errRise, hostRstCmd}.
- FSM states: IDLE, ASSERT, HOLDOFF.
  - IDLE, trig=1: go to ASSERT; sysRstReq=1 from the next cycle (latency 1); rstCause<=trigCause (replaces the old value); rstCount increments, saturating at all-ones; cycle counter<=ReqCycles-1.
  - ASSERT: sysRstReq=1; decrement the counter; at 0, go to HOLDOFF with counter<=HoldoffCycles-1. sysRstReq is high for exactly ReqCycles cycles.
  - HOLDOFF: sysRstReq=0; decrement the counter; at 0, go to IDLE, or straight to ASSERT if pending=1.
  - Pending-to-ASSERT entry: rstCause<=pendCause; rstCount increments; pending and pendCause clear.
- Triggers in ASSERT/HOLDOFF:
  - Set pending=1 and OR trigCause into pendCause; depth is one, so multiple triggers merge.
  - A trigger in the same cycle as HOLDOFF->ASSERT from pending is merged into the cause being loaded.
- Simultaneous sources in one cycle produce one request with multiple cause bits.
- Reset mid-pulse (sysRstN=0 during ASSERT): sysRstReq drops on the next cycle and all state clears; the truncated pulse is acceptable because the handler restarts on any request cycle.
- Watchdog is frozen at 0 outside IDLE, so a hung kernel causes at most one request per ReqCycles+HoldoffCycles+WdLimit cycles.
- All outputs are registered; no combinational input-to-output path.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, ASSERT=2'd1, HOLDOFF=2'd2); cause bit indices (HOST=0, ERR=1, WD=2).
- One sub-module, action_reset_watchdog: watchdog counter, enable/clear gating, wdTimeout and wdExpired. The top level holds edge detect, FSM, counters and status.

Test Plan:
- Host pulse: release reset, one-cycle hostRstCmd at cycle 10 (defaults) -> sysRstReq high cycles 11-14, rstCause=3'b001, rstCount=1; new hostRstCmd at cycle 20 -> pending, next pulse starts at cycle 47.
- Error edge: errorFlag high from cycle 5 and held -> exactly one request, rstCause=3'b010; errorFlag low then high again after holdoff -> second request, rstCount=2.
- Watchdog (WdLimit=16): wdEnable=1, kernelBusy=1, no activity -> wdExpired pulses after 16 busy-idle cycles, sysRstReq the cycle after wdTimeout, rstCause=3'b100; activity strobe every 10 cycles -> no timeout.
- Simultaneous sources: hostRstCmd and errRise in the same IDLE cycle -> single request, rstCause=3'b011, rstCount increments by 1.
- Reset mid-pulse: sysRstN=0 during the second ASSERT cycle -> next cycle sysRstReq=0, rstCount=0, rstCause=0, state IDLE, pending cleared.
- Saturation (CountSize=2): 5 spaced host commands -> rstCount reads 1,2,3,3,3.
